riscv_core_mem_wb_stage: RTL and testbench
==========================================

Name: riscv_core_mem_wb_stage

Overview:
- MEM/WB pipeline register of the RV64I core. It registers the four write-back candidates (ALU result, formatted load data, PC+4, immediate) and the 2-bit write-back select that drive the core's 4:1 write-back mux.
- It also performs load extraction and extension, flags misaligned loads, and keeps the retired-instruction counter.
- It sits between the data-memory response and the write-back mux / register file.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.
- REG_ADDR_W, 5, register index width.

Ports:
- i_clk  in  1  core clock. All state changes on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_mem_wb_valid  in  1  MEM stage presents a valid instruction.
- o_mem_wb_ready  out  1  stage can accept. Equals !i_mem_wb_stall.
- i_mem_wb_stall  in  1  downstream hold.
- i_mem_wb_flush  in  1  kill the entry being captured.
- i_mem_wb_alu_result  in  XLEN  ALU result. Its low 3 bits are also the load address offset.
- i_mem_wb_rdata  in  XLEN  raw, doubleword-aligned memory read data.
- i_mem_wb_funct3  in  3  load size and signedness.
- i_mem_wb_is_load  in  1  instruction is a load.
- i_mem_wb_pc_plus4  in  XLEN  PC+4 for JAL/JALR.
- i_mem_wb_imm  in  XLEN  immediate for LUI.
- i_mem_wb_rd  in  REG_ADDR_W  destination register.
- i_mem_wb_reg_write  in  1  instruction writes rd.
- i_mem_wb_sel  in  2  write-back select.
- o_mem_wb_valid  out  1  registered entry is valid.
- o_mem_wb_alu_result  out  XLEN  mux in0.
- o_mem_wb_load_data  out  XLEN  mux in1.
- o_mem_wb_pc_plus4  out  XLEN  mux in2.
- o_mem_wb_imm  out  XLEN  mux in3.
- o_mem_wb_sel  out  2  mux select.
- o_mem_wb_rd  out  REG_ADDR_W  destination register.
- o_mem_wb_reg_write  out  1  qualified register-file write enable.
- o_mem_wb_misaligned  out  1  load-address-misaligned exception for the registered entry.
- o_mem_wb_instret  out  64  retired-instruction count.

Behaviour:
- Reset: while i_rst_n=0 at a clock edge, every registered output is cleared to 0. This covers valid, data, sel (00), rd, reg_write, misaligned and instret. Reset is honoured mid-stall and mid-flush.
- Latency: 1 cycle from input capture to registered output. There is no combinational path from inputs to registered outputs.
- Update priority per edge is reset > flush > stall > capture:
  - Flush: o_mem_wb_valid, o_mem_wb_reg_write and o_mem_wb_misaligned go to 0. Data fields may update. Flush takes effect even when stall is asserted.
  - Stall (no flush): every register holds its value, including instret.
  - Capture: all fields are loaded from the inputs. o_mem_wb_valid = i_mem_wb_valid.
- Load format uses off = alu_result[2:0]:
  - LB / LBU (000/100): byte at rdata[8*off +: 8].
  - LH / LHU (001/101): halfword at rdata[8*off +: 16].
  - LW / LWU (010/110): word at rdata[8*off +: 32].
  - LD (011): the full 64 bits.
  - Signed loads sign-extend; U variants zero-extend to 64 bits.
  - funct3 = 111 is treated as LD. When is_load=0, load_data = 0.
- Misalignment:
  - Condition: is_load and one of (halfword and off[0]!=0), (word and off[1:0]!=0), (LD and off!=0).
  - Registered misaligned = valid & is_load & that condition.
  - When set, o_mem_wb_reg_write = 0; otherwise o_mem_wb_reg_write = valid & reg_write.
- instret:
  - Increments by 1 on a capture edge where i_mem_wb_valid=1 and the entry is not misaligned.
  - Does not increment on flush, stall or a misaligned capture.
  - Wraps modulo 2^64.
- o_mem_wb_sel and the data fields pass through unmodified. Select legality is not checked.

Decomposition:
- Shared package riscv_core_pkg holds:
  - Load funct3 constants: LB, LH, LW, LD, LBU, LHU, LWU.
  - Write-back select encodings: 2'b00 ALU, 2'b01 LOAD, 2'b10 PC4, 2'b11 IMM.
- One combinational sub-module, riscv_core_load_formatter. Inputs: rdata, offset, funct3, is_load. Outputs: load_data, misaligned.

Test Plan:
- LB signed: rdata=64'h0000_0000_0000_80FF, alu_result=...001, funct3=000, valid=1 → next cycle load_data=64'hFFFF_FFFF_FFFF_FF80, misaligned=0, instret +1. Same with funct3=100 → 64'h80.
- LW/LWU: rdata=64'h8000_0001_1234_5678, off=4. funct3=010 → 64'hFFFF_FFFF_8000_0001. funct3=110 → 64'h0000_0000_8000_0001.
- Misaligned: LW with off=2, reg_write=1 → misaligned=1, reg_write=0, valid=1, instret unchanged. LD with off=0 → misaligned=0, load_data=rdata.
- Stall: capture ALU entry (sel=00, rd=5), then assert stall with new inputs for 3 cycles → outputs and instret frozen, ready=0. Release → new entry appears one cycle later.
- Flush with stall: stall=1 and flush=1 on a valid entry → next cycle valid=0, reg_write=0, instret unchanged.
- Reset mid-operation: after 10 retirements (instret=10), drive rst_n=0 for one edge while valid=1 → all outputs 0, instret=0. The next capture gives instret=1.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// Shared RV64I core definitions: load funct3 encodings and write-back select codes.
package riscv_core_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_IMM  = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/riscv_core_load_formatter.sv
// Combinational load extraction/extension from a doubleword-aligned read beat,
// plus the natural-alignment check for the access size.
module riscv_core_load_formatter
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  input  logic            is_load,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  logic [5:0]  sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  assign sh     = {offset, 3'b000};
  assign byte_v = 8'(rdata >> sh);
  assign half_v = 16'(rdata >> sh);
  assign word_v = 32'(rdata >> sh);

  always_comb begin
    load_data  = '0;
    misaligned = 1'b0;
    if (is_load) begin
      case (funct3)
        LB:  load_data = {{(XLEN-8){byte_v[7]}}, byte_v};
        LBU: load_data = {{(XLEN-8){1'b0}}, byte_v};
        LH: begin
          load_data  = {{(XLEN-16){half_v[15]}}, half_v};
          misaligned = offset[0];
        end
        LHU: begin
          load_data  = {{(XLEN-16){1'b0}}, half_v};
          misaligned = offset[0];
        end
        LW: begin
          load_data  = {{(XLEN-32){word_v[31]}}, word_v};
          misaligned = (offset[1:0] != 2'b00);
        end
        LWU: begin
          load_data  = {{(XLEN-32){1'b0}}, word_v};
          misaligned = (offset[1:0] != 2'b00);
        end
        // LD and the unused 3'b111 encoding both return the whole doubleword.
        default: begin
          load_data  = rdata;
          misaligned = (offset != 3'b000);
        end
      endcase
    end
  end

endmodule

// File: rtl/riscv_core_mem_wb_stage.sv
// MEM/WB pipeline register: holds the four write-back mux candidates and select,
// formats load data, flags misaligned loads and counts retired instructions.
module riscv_core_mem_wb_stage
  import riscv_core_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_mem_wb_valid,
  output logic                  o_mem_wb_ready,
  input  logic                  i_mem_wb_stall,
  input  logic                  i_mem_wb_flush,
  input  logic [XLEN-1:0]       i_mem_wb_alu_result,
  input  logic [XLEN-1:0]       i_mem_wb_rdata,
  input  logic [2:0]            i_mem_wb_funct3,
  input  logic                  i_mem_wb_is_load,
  input  logic [XLEN-1:0]       i_mem_wb_pc_plus4,
  input  logic [XLEN-1:0]       i_mem_wb_imm,
  input  logic [REG_ADDR_W-1:0] i_mem_wb_rd,
  input  logic                  i_mem_wb_reg_write,
  input  logic [1:0]            i_mem_wb_sel,
  output logic                  o_mem_wb_valid,
  output logic [XLEN-1:0]       o_mem_wb_alu_result,
  output logic [XLEN-1:0]       o_mem_wb_load_data,
  output logic [XLEN-1:0]       o_mem_wb_pc_plus4,
  output logic [XLEN-1:0]       o_mem_wb_imm,
  output logic [1:0]            o_mem_wb_sel,
  output logic [REG_ADDR_W-1:0] o_mem_wb_rd,
  output logic                  o_mem_wb_reg_write,
  output logic                  o_mem_wb_misaligned,
  output logic [63:0]           o_mem_wb_instret
);

  // Handshake: the stage captures on every edge where o_mem_wb_ready (= !stall) is high;
  // i_mem_wb_valid=0 captures a bubble. Flush overrides stall and kills the captured entry.

  logic [XLEN-1:0] fmt_load_data;
  logic            fmt_misaligned;
  logic            capture;

  riscv_core_load_formatter #(.XLEN(XLEN)) u_load_formatter (
    .rdata      (i_mem_wb_rdata),
    .offset     (i_mem_wb_alu_result[2:0]),
    .funct3     (i_mem_wb_funct3),
    .is_load    (i_mem_wb_is_load),
    .load_data  (fmt_load_data),
    .misaligned (fmt_misaligned)
  );

  assign o_mem_wb_ready = !i_mem_wb_stall;
  assign capture        = !i_mem_wb_flush && !i_mem_wb_stall;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_mem_wb_valid      <= 1'b0;
      o_mem_wb_alu_result <= '0;
      o_mem_wb_load_data  <= '0;
      o_mem_wb_pc_plus4   <= '0;
      o_mem_wb_imm        <= '0;
      o_mem_wb_sel        <= WB_SEL_ALU;
      o_mem_wb_rd         <= '0;
      o_mem_wb_reg_write  <= 1'b0;
      o_mem_wb_misaligned <= 1'b0;
      o_mem_wb_instret    <= '0;
    end else begin
      // Data fields follow the inputs on flush too; only the qualifiers are killed.
      if (i_mem_wb_flush || !i_mem_wb_stall) begin
        o_mem_wb_alu_result <= i_mem_wb_alu_result;
        o_mem_wb_load_data  <= fmt_load_data;
        o_mem_wb_pc_plus4   <= i_mem_wb_pc_plus4;
        o_mem_wb_imm        <= i_mem_wb_imm;
        o_mem_wb_sel        <= i_mem_wb_sel;
        o_mem_wb_rd         <= i_mem_wb_rd;
      end
      if (i_mem_wb_flush) begin
        o_mem_wb_valid      <= 1'b0;
        o_mem_wb_reg_write  <= 1'b0;
        o_mem_wb_misaligned <= 1'b0;
      end else if (capture) begin
        o_mem_wb_valid      <= i_mem_wb_valid;
        o_mem_wb_reg_write  <= i_mem_wb_valid & i_mem_wb_reg_write & !fmt_misaligned;
        o_mem_wb_misaligned <= i_mem_wb_valid & fmt_misaligned;
        if (i_mem_wb_valid && !fmt_misaligned) begin
          o_mem_wb_instret <= o_mem_wb_instret + 64'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_mem_wb_stage.sv
// Directed bench for the MEM/WB stage: drivers push hand-computed expectations,
// a monitor compares the registered outputs one cycle after each drive.
module tb_riscv_core_mem_wb_stage;
  import riscv_core_pkg::*;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [63:0] alu;
    logic [63:0] ld;
    logic [63:0] pc4;
    logic [63:0] imm;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic [63:0] instret;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        ready;
  logic        stall;
  logic        flush;
  logic [63:0] in_alu;
  logic [63:0] in_rdata;
  logic [2:0]  in_funct3;
  logic        in_is_load;
  logic [63:0] in_pc4;
  logic [63:0] in_imm;
  logic [4:0]  in_rd;
  logic        in_rw;
  logic [1:0]  in_sel;
  logic        out_valid;
  logic [63:0] out_alu;
  logic [63:0] out_ld;
  logic [63:0] out_pc4;
  logic [63:0] out_imm;
  logic [1:0]  out_sel;
  logic [4:0]  out_rd;
  logic        out_rw;
  logic        out_mis;
  logic [63:0] out_instret;

  exp_t        exp_q[$];
  exp_t        cur;
  exp_t        mon_e;
  logic [63:0] exp_instret;
  int          seq;
  int          n_pass;
  int          n_total;

  riscv_core_mem_wb_stage #(.XLEN(64), .REG_ADDR_W(5)) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_mem_wb_valid      (in_valid),
    .o_mem_wb_ready      (ready),
    .i_mem_wb_stall      (stall),
    .i_mem_wb_flush      (flush),
    .i_mem_wb_alu_result (in_alu),
    .i_mem_wb_rdata      (in_rdata),
    .i_mem_wb_funct3     (in_funct3),
    .i_mem_wb_is_load    (in_is_load),
    .i_mem_wb_pc_plus4   (in_pc4),
    .i_mem_wb_imm        (in_imm),
    .i_mem_wb_rd         (in_rd),
    .i_mem_wb_reg_write  (in_rw),
    .i_mem_wb_sel        (in_sel),
    .o_mem_wb_valid      (out_valid),
    .o_mem_wb_alu_result (out_alu),
    .o_mem_wb_load_data  (out_ld),
    .o_mem_wb_pc_plus4   (out_pc4),
    .o_mem_wb_imm        (out_imm),
    .o_mem_wb_sel        (out_sel),
    .o_mem_wb_rd         (out_rd),
    .o_mem_wb_reg_write  (out_rw),
    .o_mem_wb_misaligned (out_mis),
    .o_mem_wb_instret    (out_instret)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: one expected snapshot per driven cycle, sampled 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("valid",      64'(out_valid),   64'(mon_e.valid));
      check("ready",      64'(ready),       64'(mon_e.ready));
      check("alu_result", out_alu,          mon_e.alu);
      check("load_data",  out_ld,           mon_e.ld);
      check("pc_plus4",   out_pc4,          mon_e.pc4);
      check("imm",        out_imm,          mon_e.imm);
      check("sel",        64'(out_sel),     64'(mon_e.sel));
      check("rd",         64'(out_rd),      64'(mon_e.rd));
      check("reg_write",  64'(out_rw),      64'(mon_e.rw));
      check("misaligned", 64'(out_mis),     64'(mon_e.mis));
      check("instret",    out_instret,      mon_e.instret);
    end
  end

  // Driver tasks
  task automatic rst_cyc(input logic st);
    @(negedge clk);
    rst_n = 1'b0; stall = st; flush = 1'b0; in_valid = 1'b1;
    in_alu = 64'h55; in_rdata = 64'h1234; in_funct3 = LB; in_is_load = 1'b1;
    in_rd = 5'd3; in_rw = 1'b1; in_sel = 2'b01;
    exp_instret = '0;
    cur = '0;
    cur.ready = !st;
    exp_q.push_back(cur);
  endtask

  task automatic cap(input logic [63:0] alu, input logic [63:0] rdata, input logic [2:0] f3,
                     input logic ld, input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                     input logic [63:0] exp_ld, input logic exp_mis);
    @(negedge clk);
    seq++;
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
    in_alu = alu; in_rdata = rdata; in_funct3 = f3; in_is_load = ld;
    in_pc4 = 64'h1000 + 64'(seq) * 4; in_imm = 64'hABCD_0000 + 64'(seq);
    in_rd = rd; in_rw = rw; in_sel = sel;
    if (!exp_mis) exp_instret++;
    cur.valid = 1'b1; cur.ready = 1'b1; cur.alu = alu; cur.ld = exp_ld;
    cur.pc4 = 64'h1000 + 64'(seq) * 4; cur.imm = 64'hABCD_0000 + 64'(seq);
    cur.sel = sel; cur.rd = rd; cur.rw = rw & !exp_mis; cur.mis = exp_mis;
    cur.instret = exp_instret;
    exp_q.push_back(cur);
  endtask

  task automatic bubble();
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_alu = 64'h77; in_rdata = 64'hFFFF; in_funct3 = LD; in_is_load = 1'b0;
    in_pc4 = 64'h2000; in_imm = 64'h3000; in_rd = 5'd11; in_rw = 1'b1; in_sel = 2'b10;
    cur.valid = 1'b0; cur.ready = 1'b1; cur.alu = 64'h77; cur.ld = '0;
    cur.pc4 = 64'h2000; cur.imm = 64'h3000; cur.sel = 2'b10; cur.rd = 5'd11;
    cur.rw = 1'b0; cur.mis = 1'b0; cur.instret = exp_instret;
    exp_q.push_back(cur);
  endtask

  // New, different inputs under stall: nothing may move.
  task automatic stall_cyc(input int k);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b1; flush = 1'b0; in_valid = 1'b1;
    in_alu = 64'hDEAD_0000 + 64'(k); in_rdata = 64'hCAFE; in_funct3 = LD; in_is_load = 1'b1;
    in_pc4 = 64'h9999; in_imm = 64'h8888; in_rd = 5'd9; in_rw = 1'b1; in_sel = 2'b01;
    cur.ready = 1'b0;
    exp_q.push_back(cur);
  endtask

  // Re-presents the last captured inputs, so data fields are the same either way.
  task automatic flush_cyc(input logic st);
    @(negedge clk);
    rst_n = 1'b1; stall = st; flush = 1'b1; in_valid = 1'b1;
    cur.valid = 1'b0; cur.rw = 1'b0; cur.mis = 1'b0; cur.ready = !st;
    exp_q.push_back(cur);
  endtask

  initial begin
    n_pass = 0; n_total = 0; seq = 0; exp_instret = '0; cur = '0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_alu = '0; in_rdata = '0; in_funct3 = LB; in_is_load = 1'b0;
    in_pc4 = '0; in_imm = '0; in_rd = '0; in_rw = 1'b0; in_sel = 2'b00;

    rst_cyc(1'b0);
    rst_cyc(1'b0);

    // Byte loads
    cap(64'h1, 64'h80FF, LB,  1'b1, 5'd1, 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    cap(64'h1, 64'h80FF, LBU, 1'b1, 5'd2, 1'b1, 2'b01, 64'h0000_0000_0000_0080, 1'b0);
    // Word loads at offset 4
    cap(64'h104, 64'h8000_0001_1234_5678, LW,  1'b1, 5'd3, 1'b1, 2'b01, 64'hFFFF_FFFF_8000_0001, 1'b0);
    cap(64'h104, 64'h8000_0001_1234_5678, LWU, 1'b1, 5'd4, 1'b1, 2'b01, 64'h0000_0000_8000_0001, 1'b0);
    // Halfword loads
    cap(64'h206, 64'h8000_0001_1234_5678, LH,  1'b1, 5'd6, 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_8000, 1'b0);
    cap(64'h202, 64'h8000_0001_1234_5678, LHU, 1'b1, 5'd7, 1'b1, 2'b01, 64'h0000_0000_0000_1234, 1'b0);
    // Misaligned word: exception, no write, no retire
    cap(64'h302, 64'h8000_0001_1234_5678, LW,  1'b1, 5'd8, 1'b1, 2'b01, 64'h0000_0000_0001_1234, 1'b1);
    // Doubleword, plus funct3=111 aliasing LD
    cap(64'h400, 64'h0123_4567_89AB_CDEF, LD,     1'b1, 5'd9,  1'b1, 2'b01, 64'h0123_4567_89AB_CDEF, 1'b0);
    cap(64'h408, 64'hFEDC_BA98_7654_3210, 3'b111, 1'b1, 5'd10, 1'b1, 2'b01, 64'hFEDC_BA98_7654_3210, 1'b0);
    // More misaligned boundaries
    cap(64'h404, 64'h0123_4567_89AB_CDEF, LD, 1'b1, 5'd12, 1'b1, 2'b01, 64'h0123_4567_89AB_CDEF, 1'b1);
    cap(64'h501, 64'h8000_0001_1234_5678, LH, 1'b1, 5'd13, 1'b1, 2'b01, 64'h0000_0000_0000_3456, 1'b1);
    // Non-load: load_data forced to 0, odd address irrelevant
    cap(64'hFFFF_FFFF_FFFF_FFF1, 64'h1111, LW, 1'b0, 5'd5, 1'b1, 2'b00, 64'h0, 1'b0);
    // Stall for three cycles with fresh inputs, then release
    for (int k = 0; k < 3; k++) stall_cyc(k);
    cap(64'h42, 64'h0, LB, 1'b0, 5'd7, 1'b1, 2'b11, 64'h0, 1'b0);
    // instret is 10 here; reset while stalled and valid
    rst_cyc(1'b1);
    cap(64'h600, 64'h0000_0000_0000_00AA, LBU, 1'b1, 5'd14, 1'b1, 2'b01, 64'hAA, 1'b0);
    bubble();
    // reg_write=0 entry, then flush with and without stall
    cap(64'h700, 64'hAAAA_BBBB_CCCC_DDDD, LD, 1'b1, 5'd15, 1'b0, 2'b01, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    cap(64'h708, 64'h5555_6666_7777_8888, LD, 1'b1, 5'd16, 1'b1, 2'b01, 64'h5555_6666_7777_8888, 1'b0);
    flush_cyc(1'b1);
    flush_cyc(1'b0);
    cap(64'h810, 64'h0, LB, 1'b0, 5'd17, 1'b1, 2'b10, 64'h0, 1'b0);

    @(negedge clk);
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
